// File: rtl/tree_mac_result_collector_pkg.sv
// Shared types and helpers for the tree MAC result collector.
// The default widths match the collector's default parameters.
package tree_mac_pkg;

  localparam int DEF_DATA_WIDTH      = 8;
  localparam int DEF_ADDRESS_WIDTH_I = 4;
  localparam int DEF_ADDRESS_WIDTH_K = 4;
  localparam int DEF_PASS_WIDTH      = 4;
  localparam int DEF_FIFO_DEPTH      = 4;
  localparam int IDX_WIDTH           = DEF_ADDRESS_WIDTH_I + DEF_ADDRESS_WIDTH_K;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0]      sum;
    logic [DEF_ADDRESS_WIDTH_I-1:0] addr_i;
    logic [DEF_ADDRESS_WIDTH_K-1:0] addr_k;
  } result_t;

  // A pass count of zero is treated as a single pass.
  function automatic logic [31:0] eff_passes(input logic [31:0] passes);
    if (passes == 32'd0) begin
      return 32'd1;
    end else begin
      return passes;
    end
  endfunction

endpackage

// File: rtl/tree_mac_result_collector_if.sv
// Input partial-sum stream and output result stream of the collector.
// The collector is the slave; the MAC core and the writeback side form the master.
interface tree_mac_result_collector_if #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDRESS_WIDTH_I = 4,
  parameter int ADDRESS_WIDTH_K = 4
);
  logic [DATA_WIDTH-1:0]      sum_in;
  logic [ADDRESS_WIDTH_I-1:0] addr_i_in;
  logic [ADDRESS_WIDTH_K-1:0] addr_k_in;
  logic                       val_in;
  logic [DATA_WIDTH-1:0]      out_sum;
  logic [ADDRESS_WIDTH_I-1:0] out_addr_i;
  logic [ADDRESS_WIDTH_K-1:0] out_addr_k;
  logic                       out_val;
  logic                       out_rdy;

  modport slave (
    input  sum_in, addr_i_in, addr_k_in, val_in, out_rdy,
    output out_sum, out_addr_i, out_addr_k, out_val
  );

  modport master (
    output sum_in, addr_i_in, addr_k_in, val_in, out_rdy,
    input  out_sum, out_addr_i, out_addr_k, out_val
  );
endinterface

// File: rtl/tree_mac_result_collector_fifo.sv
// First-word-fall-through result FIFO with registered storage.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module tree_mac_result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/tree_mac_result_collector.sv
// Accumulates partial dot products per (i,k) over cfg_passes beats and queues
// each completed result toward the writeback side; dropped results are flagged.
module tree_mac_result_collector
  import tree_mac_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH_I = DEF_ADDRESS_WIDTH_I,
  parameter int ADDRESS_WIDTH_K = DEF_ADDRESS_WIDTH_K,
  parameter int PASS_WIDTH      = DEF_PASS_WIDTH,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PASS_WIDTH-1:0] i_cfg_passes,
  tree_mac_result_collector_if.slave bus,
  output logic                  o_overflow,
  output logic                  o_busy
);
  localparam int IW      = ADDRESS_WIDTH_I + ADDRESS_WIDTH_K;
  localparam int ENTRIES = 1 << IW;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]      sum;
    logic [ADDRESS_WIDTH_I-1:0] addr_i;
    logic [ADDRESS_WIDTH_K-1:0] addr_k;
  } res_t;

  logic [DATA_WIDTH-1:0] r_acc [ENTRIES];
  logic [PASS_WIDTH-1:0] r_cnt [ENTRIES];
  logic                  r_overflow;

  logic [IW-1:0]         w_idx;
  logic [DATA_WIDTH-1:0] w_acc_cur;
  logic [PASS_WIDTH-1:0] w_cnt_cur;
  logic [PASS_WIDTH-1:0] w_passes;
  logic [DATA_WIDTH-1:0] w_new;
  logic                  w_last;
  logic                  w_pop;
  logic                  w_drop;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_any_cnt;
  res_t                  w_push_data;
  res_t                  w_head;

  assign w_idx     = {bus.addr_i_in, bus.addr_k_in};
  assign w_acc_cur = r_acc[w_idx];
  assign w_cnt_cur = r_cnt[w_idx];
  assign w_passes  = PASS_WIDTH'(eff_passes(32'(i_cfg_passes)));
  assign w_new     = (w_cnt_cur == '0) ? bus.sum_in : (w_acc_cur + bus.sum_in);
  // Compare one bit wider so a counter left above P by a config change wraps instead of matching.
  assign w_last    = bus.val_in &
                     (({1'b0, w_cnt_cur} + (PASS_WIDTH+1)'(1)) == {1'b0, w_passes});
  assign w_pop     = bus.out_val & bus.out_rdy;
  assign w_drop    = w_last & w_full & ~w_pop;

  assign w_push_data.sum    = w_new;
  assign w_push_data.addr_i = bus.addr_i_in;
  assign w_push_data.addr_k = bus.addr_k_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < ENTRIES; j++) begin
        r_acc[j] <= '0;
        r_cnt[j] <= '0;
      end
    end else if (bus.val_in) begin
      if (w_last) begin
        r_acc[w_idx] <= '0;
        r_cnt[w_idx] <= '0;
      end else begin
        r_acc[w_idx] <= w_new;
        r_cnt[w_idx] <= w_cnt_cur + PASS_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  always_comb begin
    w_any_cnt = 1'b0;
    for (int j = 0; j < ENTRIES; j++) begin
      w_any_cnt = w_any_cnt | (r_cnt[j] != '0);
    end
  end

  tree_mac_result_fifo #(
    .WIDTH ($bits(res_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_last),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign bus.out_sum    = w_head.sum;
  assign bus.out_addr_i = w_head.addr_i;
  assign bus.out_addr_k = w_head.addr_k;
  assign bus.out_val    = ~w_empty;
  assign o_overflow     = r_overflow;
  assign o_busy         = w_any_cnt | ~w_empty;
endmodule

// File: doc/tree_mac_result_collector.md
Name: tree_mac_result_collector

Overview:
- Sink-side partner of the tree MAC core. Consumes the core's delayed result stream (sum, addr_i, addr_k, val).
- Accumulates partial dot products over a configurable number of passes, for dot products longer than DATA_LENGTH.
- Emits each completed (i,k) result on a valid/ready output stream through a small output FIFO toward the writeback/output buffer.
- The input side has no backpressure (fixed-latency pipeline). Overflow is flagged, never stalled.

Parameters:
- DATA_WIDTH, 8: width of sum_in, accumulators and out_sum.
- ADDRESS_WIDTH_I, 4: row address width; accumulator index high bits.
- ADDRESS_WIDTH_K, 4: column address width; accumulator index low bits.
- PASS_WIDTH, 4: width of cfg_passes and per-entry pass counters.
- FIFO_DEPTH, 4: output FIFO entries, power of two, >=2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_passes  in  PASS_WIDTH  partial sums per result; 0 is treated as 1; change only while busy=0
- sum_in  in  DATA_WIDTH  partial sum from the MAC core
- addr_i_in  in  ADDRESS_WIDTH_I  row address of sum_in
- addr_k_in  in  ADDRESS_WIDTH_K  column address of sum_in
- val_in  in  1  sum_in/addresses valid this cycle
- out_sum  out  DATA_WIDTH  completed result
- out_addr_i  out  ADDRESS_WIDTH_I  row address of result
- out_addr_k  out  ADDRESS_WIDTH_K  column address of result
- out_val  out  1  output beat valid (FIFO non-empty)
- out_rdy  in  1  downstream accepts; transfer when out_val & out_rdy
- overflow  out  1  sticky: a completed result was dropped
- busy  out  1  any pass counter non-zero or FIFO non-empty

Behaviour:
- Reset state: all accumulators and pass counters 0, FIFO empty. out_val=0, overflow=0, busy=0. out_sum/out_addr_* = 0 while the FIFO is empty.
- Index: idx = {addr_i_in, addr_k_in}. Storage is flop arrays acc[idx] and cnt[idx], depth 2^(ADDRESS_WIDTH_I+ADDRESS_WIDTH_K).
- Per val_in beat, evaluated in a single cycle:
  - new = (cnt[idx]==0) ? sum_in : acc[idx]+sum_in, truncated mod 2^DATA_WIDTH.
  - P = max(cfg_passes,1).
  - If cnt[idx]+1 == P: push {new, addr_i_in, addr_k_in} into the FIFO; acc[idx]<=0; cnt[idx]<=0.
  - Otherwise: acc[idx]<=new; cnt[idx]<=cnt[idx]+1.
- Back-to-back beats to the same idx must accumulate correctly. The array reads the value updated in the previous cycle, with no bubble.
- Beats to different idx may interleave arbitrarily; each entry is independent.
- Latency: final partial beat at cycle t gives out_val=1 at cycle t+1 when the FIFO was empty. FIFO is first-word-fall-through and registered.
- FIFO: pop when out_val & out_rdy. Push and pop in the same cycle are both performed, including when full.
- Full push: FIFO full with no pop that cycle means the result is dropped, overflow set and held until reset, and the entry is still cleared.
- Empty pop: impossible by construction, since out_val=0.
- out_* hold stable while out_val=1 and out_rdy=0.
- val_in=0: no state change except FIFO pop.
- reset asserted mid-operation: all partials and queued results discarded; val_in ignored in reset cycles.
- cfg_passes change while busy=1: undefined results, with no requirement beyond no X-propagation and no hang.
- Address wrap: none internally; addresses index storage directly.

Decomposition:
- Shared package tree_mac_pkg:
  - index width constant (ADDRESS_WIDTH_I+ADDRESS_WIDTH_K);
  - a result struct typedef {sum, addr_i, addr_k} parameterised by the widths;
  - helper function for effective passes (0 maps to 1).
- One sub-module, tree_mac_result_fifo:
  - parameterised width/depth, first-word-fall-through;
  - push/pop/full/empty; simultaneous push+pop when full.
- Top level holds the accumulator/counter arrays and update logic.

Test Plan:
- cfg_passes=1; beat sum=5, i=2, k=3, out_rdy=1 -> next cycle out_val=1, out_sum=5, out_addr_i=2, out_addr_k=3; busy falls after the pop.
- cfg_passes=3; beats sum=10,20,30 to (1,1) on consecutive cycles -> single result 60 one cycle after third beat; no output after first two.
- cfg_passes=2; interleave (0,0):100,(0,1):7,(0,0):200,(0,1):8, DATA_WIDTH=8 -> results (0,0)=44 (300 mod 256) then (0,1)=15, in completion order.
- cfg_passes=1, out_rdy=0, 6 consecutive beats, FIFO_DEPTH=4 -> first 4 queued, beats 5–6 dropped, overflow=1 sticky. Raise out_rdy -> exactly 4 results in order, out_* stable while stalled.
- FIFO full with out_rdy=1 while pushing -> no drop, overflow stays 0, throughput one result per cycle.
- cfg_passes=2; one beat to (3,3), assert reset one cycle, then two beats of 4 to (3,3) -> single result 8; pre-reset partial lost; overflow=0.
